stoch_decorr_mat_est: RTL and testbench

- Downstream consumer of the stochastic decorrelator matrix. Converts a NUM_ROWS x NUM_COLS matrix of stochastic bitstreams back to fixed-point counts.
- Counts ones per element over a window of 2^WINDOW_LOG2 enabled cycles, then presents the count matrix through a valid/ready handshake.
- Used as the readout stage for verification and for host-visible results of stochastic matrix datapaths.

---
 rtl/stoch_decorr_mat_est_if.sv | 18 +
 rtl/stoch_decorr_mat_est.sv | 79 +++++++
 tb/tb_stoch_decorr_mat_est.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/stoch_decorr_mat_est_if.sv
// Readout bus of the stochastic matrix estimator: sample stream in, count matrix out.
// Master drives samples and acceptance; slave returns counts, valid and the sticky drop flag.
interface stoch_decorr_mat_est_if #(
    parameter int NUM_ROWS    = 2,
    parameter int NUM_COLS    = 2,
    parameter int WINDOW_LOG2 = 8
);
    logic                                              en;
    logic                                              clr;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0]                 a;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][WINDOW_LOG2:0]  y;
    logic                                              y_valid;
    logic                                              y_ready;
    logic                                              drop;

    modport master (output en, clr, a, y_ready, input y, y_valid, drop);
    modport slave  (input en, clr, a, y_ready, output y, y_valid, drop);
endinterface

// File: rtl/stoch_decorr_mat_est.sv
// Purpose: counts ones per matrix element over 2^WINDOW_LOG2 enabled samples.
// Latency: y_valid rises on the edge sampling the last enabled bit of a window.
// Backpressure: a window completing while y is held unaccepted is discarded and sets drop.
module stoch_decorr_mat_est #(
    parameter int NUM_ROWS    = 2,
    parameter int NUM_COLS    = 2,
    parameter int WINDOW_LOG2 = 8
) (
    input logic                   clk,
    input logic                   rst,
    stoch_decorr_mat_est_if.slave bus
);
    localparam int CW = WINDOW_LOG2 + 1;
    typedef logic [NUM_ROWS-1:0][NUM_COLS-1:0][CW-1:0] cnt_mat_t;

    logic [WINDOW_LOG2-1:0] wcnt;
    cnt_mat_t               acc;
    cnt_mat_t               acc_nxt;
    cnt_mat_t               y_q;
    logic                   y_valid_q;
    logic                   drop_q;
    logic                   sample;
    logic                   complete;
    logic                   slot_free;
    logic                   accept;

    // clr discards the concurrent sample, so it also suppresses completion
    assign sample    = bus.en && !bus.clr;
    assign complete  = sample && (wcnt == {WINDOW_LOG2{1'b1}});
    assign accept    = y_valid_q && bus.y_ready;
    assign slot_free = !y_valid_q || bus.y_ready;

    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < NUM_ROWS; i++) begin
            for (int j = 0; j < NUM_COLS; j++) begin
                acc_nxt[i][j] = acc[i][j] + {{WINDOW_LOG2{1'b0}}, bus.a[i][j]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt      <= '0;
            acc       <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            if (bus.clr) begin
                acc  <= '0;
                wcnt <= '0;
            end else if (bus.en) begin
                if (complete) begin
                    acc  <= '0;
                    wcnt <= '0;
                end else begin
                    acc  <= acc_nxt;
                    wcnt <= wcnt + 1'b1;
                end
            end

            if (complete) begin
                if (slot_free) begin
                    y_q       <= acc_nxt;
                    y_valid_q <= 1'b1;
                end else begin
                    drop_q <= 1'b1;
                end
            end else if (accept) begin
                y_valid_q <= 1'b0;
            end
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.drop    = drop_q;
endmodule

// File: tb/tb_stoch_decorr_mat_est.sv
// Directed and randomized bench for stoch_decorr_mat_est with a window-of-samples reference model.
module tb_stoch_decorr_mat_est;
    localparam int R  = 2;
    localparam int C  = 2;
    localparam int WL = 3;
    localparam int N  = 1 << WL;

    typedef logic [R-1:0][C-1:0]        bits_t;
    typedef logic [R-1:0][C-1:0][WL:0]  cnt_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stoch_decorr_mat_est_if #(.NUM_ROWS(R), .NUM_COLS(C), .WINDOW_LOG2(WL)) bus ();

    stoch_decorr_mat_est #(.NUM_ROWS(R), .NUM_COLS(C), .WINDOW_LOG2(WL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // reference state: samples of the open window, the output slot and the drop flag
    bits_t samples[$];
    cnt_t  m_y;
    logic  m_valid;
    logic  m_drop;
    logic  y_known;
    bits_t ones;
    cnt_t  exp_c;

    function automatic cnt_t count_window();
        cnt_t c;
        c = '0;
        foreach (samples[k])
            for (int i = 0; i < R; i++)
                for (int j = 0; j < C; j++)
                    c[i][j] = c[i][j] + (samples[k][i][j] ? 4'd1 : 4'd0);
        return c;
    endfunction

    task automatic chk_y(input string tag, input cnt_t exp);
        checks++;
        assert (bus.y === exp) else begin
            errors++;
            $error("FAIL %s y got %h exp %h", tag, bus.y, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic c, input bits_t a, input logic r, input logic rs);
        logic done;
        cnt_t w;
        rst         = rs;
        bus.en      = e;
        bus.clr     = c;
        bus.a       = a;
        bus.y_ready = r;
        done = 1'b0;
        w    = '0;
        if (rs) begin
            samples.delete();
            m_y     = '0;
            m_valid = 1'b0;
            m_drop  = 1'b0;
            y_known = 1'b1;
        end else begin
            if (c) samples.delete();
            else if (e) begin
                samples.push_back(a);
                if (samples.size() == N) begin
                    w = count_window();
                    samples.delete();
                    done = 1'b1;
                end
            end
            if (done) begin
                if (!m_valid || r) begin
                    m_y     = w;
                    m_valid = 1'b1;
                    y_known = 1'b1;
                end else m_drop = 1'b1;
            end else if (m_valid && r) begin
                m_valid = 1'b0;
                y_known = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        assert (bus.y_valid === m_valid) else begin
            errors++;
            $error("FAIL y_valid got %0b exp %0b", bus.y_valid, m_valid);
        end
        checks++;
        assert (bus.drop === m_drop) else begin
            errors++;
            $error("FAIL drop got %0b exp %0b", bus.drop, m_drop);
        end
        if (y_known) chk_y("model", m_y);
    endtask

    initial begin
        ones = '1;
        samples.delete();
        m_y = '0; m_valid = 1'b0; m_drop = 1'b0; y_known = 1'b0;
        rst = 1'b1; bus.en = 1'b0; bus.clr = 1'b0; bus.a = '0; bus.y_ready = 1'b0;

        // reset state
        cyc(0, 0, '0, 0, 1);
        cyc(0, 0, '0, 0, 1);
        chk_y("reset", '0);

        // basic count: expected {8,4,0,1}
        exp_c = '0;
        exp_c[0][0] = 4'd8; exp_c[0][1] = 4'd4; exp_c[1][0] = 4'd0; exp_c[1][1] = 4'd1;
        for (int k = 0; k < N; k++) begin
            bits_t a;
            a = '0;
            a[0][0] = 1'b1;
            a[0][1] = (k % 2 == 0);
            a[1][1] = (k == 3);
            cyc(1, 0, a, 1, 0);
        end
        chk_y("basic", exp_c);
        cyc(0, 0, '0, 1, 0);

        // EN gating with all-ones gaps
        for (int k = 0; k < N + 5; k++) begin
            bits_t a;
            if (k == 1 || k == 2 || k == 5 || k == 9 || k == 11) cyc(0, 0, ones, 1, 0);
            else begin
                a = '0;
                a[0][0] = 1'b1;
                a[0][1] = (samples.size() % 2 == 0);
                a[1][1] = (samples.size() == 3);
                cyc(1, 0, a, 1, 0);
            end
        end
        chk_y("gated", exp_c);
        cyc(0, 0, '0, 1, 0);

        // backpressure and drop
        exp_c = '0;
        for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) exp_c[i][j] = 4'd8;
        for (int k = 0; k < 2 * N; k++) cyc(1, 0, ones, 0, 0);
        chk_y("held", exp_c);
        cyc(0, 0, '0, 1, 0);
        cyc(0, 0, '0, 0, 0);

        // back-to-back: ready only on window-2 completion edge
        cyc(0, 0, '0, 0, 1);
        for (int k = 0; k < 2 * N; k++) begin
            bits_t a;
            a = '0;
            a[0][0] = (k % 2 == 0);
            cyc(1, 0, a, (k == 2 * N - 1), 0);
        end
        checks++;
        assert (bus.y[0][0] === 4'd4) else begin
            errors++;
            $error("FAIL b2b y00 got %0d exp 4", bus.y[0][0]);
        end
        cyc(0, 0, '0, 1, 0);

        // CLR mid-window
        for (int k = 0; k < 5; k++) cyc(1, 0, ones, 1, 0);
        cyc(1, 1, ones, 1, 0);
        for (int k = 0; k < N; k++) cyc(1, 0, '0, 1, 0);
        chk_y("clr", '0);
        cyc(0, 0, '0, 1, 0);

        // reset with a pending result and partial window
        for (int k = 0; k < N + 3; k++) cyc(1, 0, ones, 0, 0);
        cyc(1, 0, ones, 0, 1);
        for (int k = 0; k < N; k++) cyc(1, 0, ones, 1, 0);
        cyc(0, 0, '0, 1, 0);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            bits_t a;
            a = bits_t'($urandom_range(0, 15));
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, a,
                $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
